// File: rtl/des_permutation_engine.sv
// Iterative DES initial permutation (IP) / inverse (FP) engine, BITS_PER_CYCLE output bits per clock.
// Optional macro DES_PERM_SWAP_EN: swap the 32-bit halves ahead of FP (absorbs the final DES swap).

// One output lane: resolves output bit 'pos' of IP or FP from the latched source block.
module des_perm_lane (
    input  logic [0:63] src,
    input  logic        mode,
    input  logic [5:0]  pos,
    output logic        bit_o
);
    // FIPS-46 tables, stored 0-based (entry = DES bit number - 1)
    localparam int IP_T [64] = '{
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7,
        56, 48, 40, 32, 24, 16,  8,  0,
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6
    };
    localparam int FP_T [64] = '{
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25,
        32,  0, 40,  8, 48, 16, 56, 24
    };

    always_comb begin
        bit_o = mode ? src[FP_T[pos]] : src[IP_T[pos]];
    end
endmodule

module des_permutation_engine #(
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set,
    input  logic        mode,
    input  logic [0:63] data_in,
    output logic        ready,
    output logic        status,
    output logic [0:63] data_out
);
    localparam int N     = 64 / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (BITS_PER_CYCLE != 1  && BITS_PER_CYCLE != 2  && BITS_PER_CYCLE != 4 &&
        BITS_PER_CYCLE != 8  && BITS_PER_CYCLE != 16 && BITS_PER_CYCLE != 32 &&
        BITS_PER_CYCLE != 64) begin : g_bad_bpc
        $error("des_permutation_engine: BITS_PER_CYCLE must be 1, 2, 4, 8, 16, 32 or 64");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [0:63]        src_q, src_d;
    logic [0:63]        work_q, work_d;
    logic [0:63]        dout_q, dout_d;

    logic [BITS_PER_CYCLE-1:0]      lane_bit;
    logic [BITS_PER_CYCLE-1:0][5:0] lane_pos;

    for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_lane
        assign lane_pos[j] = 6'(32'(cnt_q) * BITS_PER_CYCLE + j);
        des_perm_lane u_lane (
            .src   (src_q),
            .mode  (mode_q),
            .pos   (lane_pos[j]),
            .bit_o (lane_bit[j])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        src_d   = src_q;
        work_d  = work_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (set) begin
                    src_d = data_in;
`ifdef DES_PERM_SWAP_EN
                    if (mode) src_d = {data_in[32:63], data_in[0:31]};
`endif
                    mode_d  = mode;
                    cnt_d   = '0;
                    work_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int j = 0; j < BITS_PER_CYCLE; j++) begin
                    work_d[lane_pos[j]] = lane_bit[j];
                end
                cnt_d = cnt_q + CNT_W'(1);
                // data_out only moves here, so it holds the last result through a new run
                if (cnt_q == CNT_W'(N - 1)) begin
                    dout_d  = work_d;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            src_q   <= '0;
            work_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            work_q  <= work_d;
            dout_q  <= dout_d;
        end
    end

    assign ready    = (state_q != S_RUN);
    assign status   = (state_q == S_DONE);
    assign data_out = dout_q;
endmodule

// File: doc/des_permutation_engine.md
# des_permutation_engine

Parametrised DES permutation unit that applies either the initial permutation (IP) or its inverse (IP⁻¹/FP) to a 64-bit block. It sits at the entry and exit of the DES datapath, replacing a fixed single-mode permutation. Output bits are computed iteratively, `BITS_PER_CYCLE` per clock, under a set/status start-done handshake, so the area/latency trade-off is chosen at build time.

## Interface
- `BITS_PER_CYCLE`, default 8: output bits resolved per clock. Legal values are 1, 2, 4, 8, 16, 32, 64; any other value is an elaboration error.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `set` input, 1 bit: start strobe, sampled on the rising edge.
- `mode` input, 1 bit: 0 = IP, 1 = IP⁻¹ (FP). Sampled with `set`.
- `data_in` input, [0:63]: input block. Bit 0 is DES bit 1 (MSB). Sampled with `set`.
- `ready` output, 1 bit: high when a `set` will be accepted.
- `status` output, 1 bit: high while `data_out` holds a completed result.
- `data_out` output, [0:63]: permuted block, same bit numbering as `data_in`.

## Operation
- N = 64 / `BITS_PER_CYCLE` iterations per block. A chunk counter is ceil(log2(N)) bits wide, with a minimum of 1 bit.
- FSM states:
  - IDLE: `ready`=1, `status`=0.
  - RUN: `ready`=0, `status`=0.
  - DONE: `ready`=1, `status`=1.
- IDLE or DONE, with `set`=1:
  - latch `data_in` into `src_reg` and `mode` into `mode_reg`;
  - clear the counter and the work register;
  - go to RUN.
- RUN, each cycle: write work-register bits [cnt·B … cnt·B+B−1], where out[k] = src_reg[T[k]−1]. T is the standard FIPS-46 IP table or FP table, selected by `mode_reg`. Then increment `cnt`.
- RUN, on the cycle with `cnt` = N−1:
  - copy the completed work word into `data_out`;
  - go to DONE.
- `data_out` changes only on that completion edge or on reset. It is stable in every other cycle, including during a new RUN.
- `set` while in RUN is ignored; `src_reg`, `mode_reg` and `cnt` are unaffected.
- DONE persists until the next accepted `set` or reset. A `set` in DONE starts a new block: `status` falls on that edge.
- Reset values: FSM=IDLE, `cnt`=0, `ready`=1, `status`=0, `data_out`=64'h0, and all internal registers 0.
- Reset asserted mid-RUN aborts the block. After release the unit is in IDLE and `data_out` stays 0 until the next completion.

## Timing
- `set` accepted at edge t: `ready` is low from edge t and `status` is high from edge t+N. For `BITS_PER_CYCLE`=64, `status` is high from edge t+1.
- Throughput: one block per N cycles, because `set` is accepted in DONE. Back-to-back blocks give `status` high for exactly one cycle between them.
- `ready` and `status` are registered state decodes; there are no combinational paths from inputs to outputs.

## Configuration
- `DES_PERM_SWAP_EN` defined: when `mode`=1 is latched, the two 32-bit halves of `data_in` are swapped before FP (input L16R16 gives output FP(R16L16)). This absorbs the final DES swap. IP mode is unaffected.
- Undefined: no swap; FP is applied to `data_in` as given.

## Test plan
- Reset with `rst_n`=0 → `ready`=1, `status`=0, `data_out`=0. Hold `set`=1 while reset is asserted → nothing starts.
- `BITS_PER_CYCLE`=8, `mode`=0, `data_in`=64'h0123456789ABCDEF, `set` pulse at edge t → `status` rises at edge t+8 and `data_out`=64'hCC00CCFFF0AAF0AA.
- `mode`=1, swap macro undefined, `data_in`=64'h0A4CD99543423234 → `data_out`=64'h85E813540F0AB405. With `DES_PERM_SWAP_EN` defined, `data_in`=64'h434232340A4CD995 → same `data_out`.
- `set` pulse with a new `data_in` during RUN → ignored; the result matches the first block and the latency is unchanged. Back-to-back `set` in DONE → second result correct, `status` low for exactly N cycles.
- `rst_n` pulsed at cycle 3 of RUN → after release: IDLE, `data_out`=0. A new block then completes correctly.
- Repeat the IP and FP vectors at `BITS_PER_CYCLE`=1 (latency 64) and 64 (latency 1). Check the round trip: FP(IP(x))=x for 1000 random x.
